// File: rtl/writeback.sv
// Writeback stage: retires one execute result per transaction by writing a
// register (optionally EDX as a second beat), or a memory word held until
// acknowledged, then merges the captured flags into the architectural EFLAGS.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    result handshake; in_ready is high only in IDLE
//   in_opc               command code, captured for trace only
//   in_res_lo/in_res_hi  result words; hi goes to EDX when in_wide is set
//   in_wide              request a second register beat to EDX
//   in_dst_kind          0 none, 1 register, 2 memory, 3 treated as none
//   in_dst_reg           destination register index
//   in_dst_addr          destination memory address
//   in_flags/in_flags_mask  flag values and the EFLAGS bits they update
//   reg_we/reg_waddr/reg_wdata  register-file write port
//   mem_req/mem_addr/mem_wdata/mem_ack  memory write request, held until ack
//   eflags               architectural EFLAGS (bit 1 always reads 1)
//   retire               one-cycle pulse per completed result
module writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opc,
  input  logic [31:0] in_res_lo,
  input  logic [31:0] in_res_hi,
  input  logic        in_wide,
  input  logic [1:0]  in_dst_kind,
  input  logic [2:0]  in_dst_reg,
  input  logic [31:0] in_dst_addr,
  input  logic [31:0] in_flags,
  input  logic [31:0] in_flags_mask,
  output logic        reg_we,
  output logic [2:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [31:0] eflags,
  output logic        retire
);

  localparam logic [1:0]  KIND_NONE = 2'd0;
  localparam logic [1:0]  KIND_REG  = 2'd1;
  localparam logic [1:0]  KIND_MEM  = 2'd2;
  localparam logic [2:0]  REG_EDX   = 3'd2;
  localparam logic [31:0] EFLAGS_RSVD = 32'h0000_0002;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_LO    = 2'd1,
    WR_HI    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [5:0]  opc;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        wide;
  logic [1:0]  dst_kind;
  logic [2:0]  dst_reg;
  logic [31:0] dst_addr;
  logic [31:0] flags;
  logic [31:0] flags_mask;
  logic [31:0] eflags_r;

  logic        accept;
  logic        retire_raw;

  // The opcode is kept only so it is visible in the captured state for trace.
  logic        unused_opc;
  assign unused_opc = ^opc;

  assign accept = in_valid & in_ready;

  // State register and captured transaction fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      opc        <= '0;
      res_lo     <= '0;
      res_hi     <= '0;
      wide       <= 1'b0;
      dst_kind   <= KIND_NONE;
      dst_reg    <= '0;
      dst_addr   <= '0;
      flags      <= '0;
      flags_mask <= '0;
      eflags_r   <= EFLAGS_RSVD;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opc        <= in_opc;
        res_lo     <= in_res_lo;
        res_hi     <= in_res_hi;
        wide       <= in_wide;
        // Reserved kind is folded into "none" at capture time.
        dst_kind   <= (in_dst_kind == 2'd3) ? KIND_NONE : in_dst_kind;
        dst_reg    <= in_dst_reg;
        dst_addr   <= in_dst_addr;
        flags      <= in_flags;
        flags_mask <= in_flags_mask;
      end
      if (retire_raw) begin
        eflags_r <= (eflags_r & ~flags_mask) | (flags & flags_mask) | EFLAGS_RSVD;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (in_dst_kind == KIND_MEM) ? MEM_WAIT : WR_LO;
        end
      end
      WR_LO:    state_nxt = wide ? WR_HI : IDLE;
      WR_HI:    state_nxt = IDLE;
      MEM_WAIT: state_nxt = mem_ack ? IDLE : MEM_WAIT;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready   = 1'b0;
    reg_we     = 1'b0;
    reg_waddr  = dst_reg;
    reg_wdata  = res_lo;
    mem_req    = 1'b0;
    retire_raw = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      WR_LO: begin
        reg_we     = (dst_kind == KIND_REG);
        retire_raw = ~wide;
      end
      WR_HI: begin
        // EDX is written even when the low word had no destination.
        reg_we     = 1'b1;
        reg_waddr  = REG_EDX;
        reg_wdata  = res_hi;
        retire_raw = 1'b1;
      end
      MEM_WAIT: begin
        mem_req    = 1'b1;
        retire_raw = mem_ack;
      end
      default: ;
    endcase
  end

  // Address/data come straight from capture registers, so they cannot move
  // while the request waits for its acknowledge.
  assign mem_addr  = dst_addr;
  assign mem_wdata = res_lo;
  assign eflags    = eflags_r;
  // A reset edge abandons the operation, so the pulse is suppressed there.
  assign retire    = retire_raw & rst_n;

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  execute result present
- in_ready  out  1  block can accept a result
- in_opc  in  6  command code, carried for trace only
- in_res_lo  in  32  result low word
- in_res_hi  in  32  result high word (MUL/IMUL)
- in_wide  in  1  write in_res_hi to EDX
- in_dst_kind  in  2  destination: 0 none, 1 register, 2 memory, 3 reserved
- in_dst_reg  in  3  destination register index
- in_dst_addr  in  32  destination memory address
- in_flags  in  32  flag values computed by execute
- in_flags_mask  in  32  EFLAGS bits to update
- reg_we  out  1  register write strobe
- reg_waddr  out  3  register write index
- reg_wdata  out  32  register write data
- mem_req  out  1  memory write request
- mem_addr  out  32  memory write address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory write accepted
- eflags  out  32  architectural EFLAGS
- retire  out  1  one-cycle instruction-complete pulse

Function
REQ-003 The FSM SHALL have states IDLE, WR_LO, WR_HI and MEM_WAIT.
REQ-004 in_ready SHALL be 1 only in IDLE.
REQ-005 An accept (in_valid & in_ready) SHALL register every in_* field and move to WR_LO, or to MEM_WAIT if in_dst_kind=2.
REQ-006 in_dst_kind=3 SHALL be treated as 0.
REQ-007 In WR_LO with kind 1: reg_we=1, reg_waddr=captured in_dst_reg, reg_wdata=captured in_res_lo.
REQ-008 In WR_LO with kind 0: reg_we=0.
REQ-009 From WR_LO, a captured in_wide=1 SHALL go to WR_HI; otherwise the block SHALL assert retire and return to IDLE.
REQ-010 In WR_HI: reg_we=1, reg_waddr=3'd2 (EDX), reg_wdata=captured in_res_hi, retire=1, next state IDLE.
REQ-011 In_wide with kind 0 SHALL still write EDX in WR_HI.
REQ-012 In MEM_WAIT: mem_req=1, mem_addr and mem_wdata equal the captured values and are stable until acknowledged.
REQ-013 mem_ack sampled high while mem_req=1 SHALL complete the write: retire=1 that cycle, next state IDLE.
REQ-014 mem_ack while mem_req=0 SHALL be ignored.
REQ-015 in_wide SHALL be ignored for kind 2.
REQ-016 In the retire cycle, eflags SHALL load (eflags & ~mask) | (flags & mask) at the clock edge, using the captured flags and mask.
REQ-017 eflags bit 1 SHALL always read 1.
REQ-018 Latency from accept edge to retire: 1 cycle for narrow/none, 2 cycles for wide, 1 + ack wait for memory.
REQ-019 Throughput: one accept at most every 2 cycles, since IDLE follows every retire.
REQ-020 reg_we and mem_req SHALL never be high in the same cycle.
REQ-021 retire SHALL be high for exactly one cycle per accepted result.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL take the following values: state=IDLE, in_ready=1 the following cycle, reg_we=0, mem_req=0, retire=0, eflags=32'h0000_0002, captured registers=0.
REQ-023 Reset asserted in any state, including MEM_WAIT or WR_HI, SHALL abandon the operation: no retire, no further write, no EFLAGS update, and mem_req low after that edge.
REQ-024 An accept SHALL NOT occur on a clock edge where rst_n=0.

Verification
REQ-025 Register write: accept kind=1, reg=3, res_lo=0x1234_5678, mask=0x8D5, flags=0x0C1 -> the next cycle shows reg_we=1, waddr=3, wdata=0x1234_5678 and retire=1, and eflags then reads 0x0000_00C3.
REQ-026 Wide MUL: accept kind=1, reg=0, in_wide=1, lo=0xFFFF_FFFE, hi=0x1 -> cycle+1 writes r0=0xFFFF_FFFE with no retire, then cycle+2 writes r2=0x1 with retire=1.
REQ-027 Memory with stall: accept kind=2, addr=0x1000, lo=0xDEAD_BEEF, mem_ack held low for 3 cycles -> mem_req is held with stable addr/data and in_ready=0, and when mem_ack=1 retire=1 in that same cycle, with in_ready=1 the next cycle.
REQ-028 Kind 0 and kind 3 with mask=0: accept -> no reg_we or mem_req, retire after 1 cycle, eflags unchanged.
REQ-029 Reset mid-memory: reset applied in MEM_WAIT before mem_ack -> mem_req=0, no retire, eflags=0x2, in_ready=1 after reset release.
REQ-030 Back-to-back: in_valid held high with two results -> the second is accepted only in IDLE, and 2 retires occur with no lost or duplicate writes.
